// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer: WORDS x 4-bit two's-complement add/sub using one 4-bit slice, LSB nibble first.
// Ports: clk, reset_n (async active-low); in_valid/in_ready/op_sub/a/b operand handshake;
// out_valid/out_ready/result/carryout/overflow result handshake; busy high in RUN or DONE.
// Optional: define ADDSEQ_SATURATE_EN to saturate result on signed overflow.
module nibble_add_sequencer #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 op_sub,
   input  logic [4*WORDS-1:0]   a,
   input  logic [4*WORDS-1:0]   b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*WORDS-1:0]   result,
   output logic                 carryout,
   output logic                 overflow,
   output logic                 busy
);
   localparam int W  = 4 * WORDS;
   localparam int CW = $clog2(WORDS);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [W-1:0]  ra, rb;
   logic          carry;
   logic [CW-1:0] cnt;
   logic [4:0]    nib;
   logic          last, c3;
   assign nib  = {1'b0, ra[4*cnt +: 4]} + {1'b0, rb[4*cnt +: 4]} + {4'b0, carry};
   assign last = cnt == CW'(WORDS - 1);
   // carry into the MSB recovered from the MSB sum bit (s = a ^ b ^ cin)
   assign c3   = nib[3] ^ ra[W-1] ^ rb[W-1];
`ifdef ADDSEQ_SATURATE_EN
   // overflow only happens when both effective operands share a sign; that sign picks the rail
   logic [W-1:0] sat;
   assign sat = ra[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
   always_comb begin
      state_nx  = (state == IDLE && in_valid) ? RUN :
                  (state == RUN && last) ? DONE :
                  (state == DONE && out_ready) ? IDLE : state;
      in_ready  = state == IDLE;
      out_valid = state == DONE;
      busy      = state != IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ra       <= '0;
         rb       <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         result   <= '0;
         carryout <= 1'b0;
         overflow <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         ra    <= a;
         rb    <= op_sub ? ~b : b;
         carry <= op_sub;
         cnt   <= '0;
      end else if (state == RUN) begin
         result[4*cnt +: 4] <= nib[3:0];
         carry              <= nib[4];
         cnt                <= cnt + 1'b1;
         if (last) begin
            carryout <= nib[4];
            overflow <= c3 ^ nib[4];
`ifdef ADDSEQ_SATURATE_EN
            if (c3 ^ nib[4]) result <= sat;
`endif
         end
      end
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer: randomized and directed bench for nibble_add_sequencer against an arithmetic model.
module tb_nibble_add_sequencer;
   localparam int WORDS = 4;
   localparam int W = 4 * WORDS;
   localparam longint MAXP = 2**(W-1) - 1;
   localparam longint MINN = -(2**(W-1));
   logic clk = 0, reset_n = 0, in_valid = 0, op_sub = 0, out_ready = 0;
   logic [W-1:0] a = '0, b = '0;
   logic in_ready, out_valid, carryout, overflow, busy;
   logic [W-1:0] result;
   int checks = 0, errors = 0;

   nibble_add_sequencer #(.WORDS(WORDS)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_sub(op_sub), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carryout(carryout), .overflow(overflow), .busy(busy));

   always #5 clk = ~clk;

   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                 output logic [W-1:0] r, output logic c, output logic v);
      longint sx, sy, t;
      logic [W:0] u;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      t  = s ? sx - sy : sx + sy;
      u  = s ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y};
      c  = u[W];
      v  = (t > MAXP) || (t < MINN);
      r  = u[W-1:0];
`ifdef ADDSEQ_SATURATE_EN
      if (v) r = (t > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                         output logic [W-1:0] r, output logic c, output logic v,
                         output int lat, output logic ok);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      ok = in_ready;
      a = x; b = y; op_sub = s; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      ok = ok && out_valid;
      r = result; c = carryout; v = overflow;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   task automatic test_reset;
      reset_n = 0;
      #2;
      checks++;
      if ({in_ready, out_valid, busy, carryout, overflow} !== 5'b10000 || result !== '0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b busy=%b co=%b ov=%b result=%h required 1 0 0 0 0 0000",
                  in_ready, out_valid, busy, carryout, overflow, result);
      end
      @(negedge clk);
      reset_n = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed;
      logic [W-1:0] va[6] = '{16'h7FFF, 16'hFFFF, 16'h0002, 16'h8000, 16'h8000, 16'h0000};
      logic [W-1:0] vb[6] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h8000};
      logic         vs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [W-1:0] r, er;
      logic c, v, ec, ev, ok;
      int lat;
      for (int i = 0; i < 6; i++) begin
         run_op(va[i], vb[i], vs[i], r, c, v, lat, ok);
         model(va[i], vb[i], vs[i], er, ec, ev);
         checks++;
         if (!ok || lat != WORDS) begin
            errors++;
            $display("FAIL directed%0d latency: got %0d ok=%b required %0d", i, lat, ok, WORDS);
         end
         checks++;
         if (r !== er || c !== ec || v !== ev) begin
            errors++;
            $display("FAIL directed%0d %h %s %h: got %h c=%b v=%b required %h c=%b v=%b",
                     i, va[i], vs[i] ? "-" : "+", vb[i], r, c, v, er, ec, ev);
         end
      end
   endtask

   task automatic test_random;
      logic [W-1:0] x, y, r, er;
      logic s, c, v, ec, ev, ok;
      int lat;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom); y = W'($urandom); s = 1'($urandom);
         run_op(x, y, s, r, c, v, lat, ok);
         model(x, y, s, er, ec, ev);
         checks++;
         if (!ok || r !== er || c !== ec || v !== ev) begin
            errors++;
            $display("FAIL random%0d %h %s %h: got %h c=%b v=%b ok=%b required %h c=%b v=%b",
                     i, x, s ? "-" : "+", y, r, c, v, ok, er, ec, ev);
         end
      end
   endtask

   task automatic test_backpressure;
      logic [W-1:0] held, y2, er;
      logic ec, ev;
      int n;
      a = 16'h4321; b = 16'h1111; op_sub = 1; in_valid = 1;
      @(posedge clk); #1;
      y2 = W'($urandom);
      a = 16'h0F0F; b = y2; op_sub = 0;
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      held = result;
      checks++;
      if (held !== 16'h3210) begin
         errors++;
         $display("FAIL backpressure first: got %h required 3210", held);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (result !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure hold%0d: result=%h in_ready=%b out_valid=%b required %h 0 1",
                     i, result, in_ready, out_valid, held);
         end
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL backpressure release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL backpressure second accept: busy=%b required 1", busy);
      end
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      model(16'h0F0F, y2, 1'b0, er, ec, ev);
      checks++;
      if (!out_valid || result !== er || carryout !== ec || overflow !== ev) begin
         errors++;
         $display("FAIL backpressure second: got %h c=%b v=%b required %h c=%b v=%b",
                  result, carryout, overflow, er, ec, ev);
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
   endtask

   task automatic test_reset_mid;
      logic [W-1:0] r;
      logic c, v, ok;
      int lat, seen;
      a = 16'h5555; b = 16'h3333; op_sub = 0; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 0;
      #1;
      checks++;
      if ({in_ready, out_valid, busy, carryout, overflow} !== 5'b10000 || result !== '0) begin
         errors++;
         $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b co=%b ov=%b result=%h required 1 0 0 0 0 0000",
                  in_ready, out_valid, busy, carryout, overflow, result);
      end
      seen = 0;
      repeat (2) begin @(posedge clk); #1; if (out_valid) seen++; end
      reset_n = 1;
      repeat (6) begin @(posedge clk); #1; if (out_valid) seen++; end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid pulse: out_valid seen %0d times required 0", seen);
      end
      run_op(16'h1234, 16'h1111, 1'b0, r, c, v, lat, ok);
      checks++;
      if (!ok || r !== 16'h2345 || c !== 1'b0 || v !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid next: got %h c=%b v=%b ok=%b required 2345 c=0 v=0", r, c, v, ok);
      end
   endtask

   task automatic test_back_to_back;
      int acc_cyc[$];
      logic [W-1:0] exp_r[$];
      logic exp_c[$], exp_v[$];
      logic [W-1:0] er;
      logic ec, ev;
      int got;
      got = 0;
      a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      in_valid = 1; out_ready = 1;
      for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
         if (out_valid) begin
            checks++;
            if (exp_r.size() == 0) begin
               errors++;
               $display("FAIL b2b unexpected result %h", result);
            end else begin
               if (result !== exp_r[0] || carryout !== exp_c[0] || overflow !== exp_v[0]) begin
                  errors++;
                  $display("FAIL b2b result%0d: got %h c=%b v=%b required %h c=%b v=%b",
                           got, result, carryout, overflow, exp_r[0], exp_c[0], exp_v[0]);
               end
               void'(exp_r.pop_front()); void'(exp_c.pop_front()); void'(exp_v.pop_front());
            end
            got++;
         end
         if (in_ready && in_valid) begin
            model(a, b, op_sub, er, ec, ev);
            exp_r.push_back(er); exp_c.push_back(ec); exp_v.push_back(ev);
            acc_cyc.push_back(cyc);
         end
         @(posedge clk); #1;
         if (acc_cyc.size() == 3) in_valid = 0;
         a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
      end
      in_valid = 0; out_ready = 0;
      checks++;
      if (got != 3 || acc_cyc.size() != 3) begin
         errors++;
         $display("FAIL b2b count: results %0d accepts %0d required 3 3", got, acc_cyc.size());
      end else if (acc_cyc[1] - acc_cyc[0] != WORDS + 2 || acc_cyc[2] - acc_cyc[1] != WORDS + 2) begin
         errors++;
         $display("FAIL b2b interval: gaps %0d %0d required %0d", acc_cyc[1] - acc_cyc[0],
                  acc_cyc[2] - acc_cyc[1], WORDS + 2);
      end
   endtask

   initial begin
      test_reset;
      test_directed;
      test_random;
      test_backpressure;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
